// File: rtl/lnf_pkg.sv
// Shared types and constants for the three-lane nibble feeder.
// Holds the FSM encoding, lane/word widths and the FIFO entry layout {last, data}.
package lnf_pkg;

   localparam int unsigned LANE_W  = 4;
   localparam int unsigned WORD_W  = 12;
   localparam int unsigned ENTRY_W = WORD_W + 1;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StSend = 2'd1,
      StWait = 2'd2
   } state_t;

   typedef struct packed {
      logic              last;
      logic [WORD_W-1:0] data;
   } entry_t;

   // Lane 2 = E (msb nibble), lane 1 = F, lane 0 = G.
   function automatic logic [LANE_W-1:0] lane_of(input logic [WORD_W-1:0] word,
                                                 input int unsigned idx);
      return word[idx*LANE_W +: LANE_W];
   endfunction

endpackage

// File: rtl/lnf_fifo.sv
// Synchronous DEPTH x entry_t FIFO with full/empty flags and an occupancy count.
// Pointers wrap naturally because DEPTH is a power of two.
module lnf_fifo
   import lnf_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  entry_t                   wdata,
   input  logic                     pop,
   output entry_t                   rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
   localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);

   entry_t        mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [AW:0]   lvl;
   logic          do_push;
   logic          do_pop;

   assign full    = (lvl == LVL_FULL);
   assign empty   = (lvl == '0);
   assign level   = lvl;
   assign rdata   = mem[rptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         lvl  <= '0;
      end else begin
         if (do_push) wptr <= wptr + PTR_ONE;
         if (do_pop)  rptr <= rptr + PTR_ONE;
         if (do_push && !do_pop)      lvl <= lvl + LVL_ONE;
         else if (do_pop && !do_push) lvl <= lvl - LVL_ONE;
      end
   end

   // Storage needs no reset: only entries below the level are ever read.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wdata;
   end

endmodule

// File: rtl/lane_nibble_feeder.sv
// Feeder that buffers 12-bit words and presents them as E/F/G nibble lanes with framing strobes.
// Build option: define LNF_PARITY_EN to generate out_par; otherwise out_par is tied 0.
module lane_nibble_feeder
   import lnf_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned GAP     = 0,
   parameter int unsigned PAR_ODD = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [WORD_W-1:0]      in_data,
   input  logic                   in_last,
   output logic                   in_ready,
   output logic [LANE_W-1:0]      out_e,
   output logic [LANE_W-1:0]      out_f,
   output logic [LANE_W-1:0]      out_g,
   output logic                   out_vld,
   output logic                   out_sof,
   output logic                   out_eof,
   output logic                   out_par,
   input  logic                   out_ack,
   output logic [$clog2(DEPTH):0] fifo_lvl
);

   localparam logic [3:0] GAP_INIT = (GAP == 0) ? 4'd0 : 4'(GAP - 1);
   localparam logic       PAR_INV  = (PAR_ODD != 0);

   state_t     state;
   logic [3:0] gap_cnt;
   logic       sof_pend;

   entry_t     wr_entry;
   entry_t     rd_entry;
   logic       fifo_full;
   logic       fifo_empty;
   logic       acked;
   logic       load;
   logic       sof_src;

   assign wr_entry = '{last: in_last, data: in_data};
   assign in_ready = !fifo_full;

   lnf_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_valid),
      .wdata (wr_entry),
      .pop   (load),
      .rdata (rd_entry),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_lvl)
   );

   assign acked = (state == StSend) && out_ack;

   // An expired gap loads directly so the idle run is exactly GAP cycles.
   always_comb begin
      load = 1'b0;
      if (!fifo_empty) begin
         unique case (state)
            StIdle:  load = 1'b1;
            StSend:  load = out_ack && (GAP == 0);
            StWait:  load = (gap_cnt == 4'd0);
            default: load = 1'b0;
         endcase
      end
   end

   // An eof beat acked on the same edge as the next load makes that load a frame start.
   assign sof_src = (acked && out_eof) ? 1'b1 : sof_pend;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= StIdle;
         gap_cnt  <= 4'd0;
         sof_pend <= 1'b1;
         out_e    <= '0;
         out_f    <= '0;
         out_g    <= '0;
         out_vld  <= 1'b0;
         out_sof  <= 1'b0;
         out_eof  <= 1'b0;
      end else begin
         if (acked && out_eof) sof_pend <= 1'b1;

         unique case (state)
            StIdle: ;
            StSend: begin
               if (out_ack) begin
                  out_vld <= 1'b0;
                  if (GAP == 0) begin
                     state <= StIdle;
                  end else begin
                     gap_cnt <= GAP_INIT;
                     state   <= StWait;
                  end
               end
            end
            StWait: begin
               if (gap_cnt == 4'd0) state   <= StIdle;
               else                 gap_cnt <= gap_cnt - 4'd1;
            end
            default: state <= StIdle;
         endcase

         if (load) begin
            out_e    <= lane_of(rd_entry.data, 2);
            out_f    <= lane_of(rd_entry.data, 1);
            out_g    <= lane_of(rd_entry.data, 0);
            out_eof  <= rd_entry.last;
            out_sof  <= sof_src;
            out_vld  <= 1'b1;
            sof_pend <= 1'b0;
            state    <= StSend;
         end
      end
   end

`ifdef LNF_PARITY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_par <= 1'b0;
      end else if (load) begin
         out_par <= (^rd_entry.data) ^ PAR_INV;
      end
   end
`else
   // PAR_ODD has no effect without parity; the AND folds to constant 0.
   assign out_par = PAR_INV & 1'b0;
`endif

endmodule
